// File: rtl/en_reg_pkg.sv
// Shared constants and types for the elastic enable-register pipeline.
package en_reg_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 4;

  // One pipeline stage at the default data width.
  typedef struct packed {
    logic                 vld;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

  // Width needed to count 0..depth valid stages.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/en_reg_stage.sv
// One elastic stage: valid flop plus WIDTH-bit enable register.
// Flush clears only the valid bit; data captures on load of a valid word.
module en_reg_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             CLRN,
  input  logic             flush,
  input  logic             load,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o
);

  logic             vld_d, vld_q;
  logic [WIDTH-1:0] data_d, data_q;

  // Bubbles leave data untouched so an empty output still shows the last word.
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (load) begin
      vld_d = vld_i;
      if (vld_i) begin
        data_d = data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;

endmodule

// File: rtl/en_reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with a combinational ready chain.
// Optional occupancy counter on OCC when EN_REG_PIPE_OCC_EN is defined.
module en_reg_pipe
  import en_reg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             CLRN,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] D,
  input  logic             FLUSH,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] Q
`ifdef EN_REG_PIPE_OCC_EN
  ,
  output logic [occ_w(DEPTH)-1:0] OCC
`endif
);

  logic [DEPTH-1:0]            vld_s;
  logic [DEPTH-1:0]            rdy_c;
  logic [DEPTH-1:0][WIDTH-1:0] data_s;

  // A stage can load when it is empty or its downstream neighbour moves.
  always_comb begin : ready_chain
    logic r;
    rdy_c = '0;
    r = ~vld_s[DEPTH-1] | out_rdy;
    rdy_c[DEPTH-1] = r;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      r = ~vld_s[i] | r;
      rdy_c[i] = r;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_vld;
    logic [WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_vld  = in_vld & ~FLUSH;
      assign up_data = D;
    end else begin : g_body
      assign up_vld  = vld_s[i-1];
      assign up_data = data_s[i-1];
    end

    en_reg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk    (clk),
      .CLRN   (CLRN),
      .flush  (FLUSH),
      .load   (rdy_c[i]),
      .vld_i  (up_vld),
      .data_i (up_data),
      .vld_o  (vld_s[i]),
      .data_o (data_s[i])
    );
  end

  assign in_rdy  = rdy_c[0] & ~FLUSH;
  assign out_vld = vld_s[DEPTH-1];
  assign Q       = data_s[DEPTH-1];

`ifdef EN_REG_PIPE_OCC_EN
  localparam int unsigned OCC_W = occ_w(DEPTH);

  logic             in_xfer, out_xfer;
  logic [OCC_W-1:0] occ_d, occ_q;

  assign in_xfer  = in_vld & in_rdy;
  assign out_xfer = out_vld & out_rdy;

  // Flush empties every stage, so any transfer in that cycle is moot.
  always_comb begin
    occ_d = occ_q;
    if (FLUSH) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge CLRN) begin
    if (!CLRN) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign OCC = occ_q;
`endif

endmodule

// File: tb/tb_en_reg_pipe.sv
// Self-checking bench for en_reg_pipe: DEPTH=4 and DEPTH=1 instances against a slot model.
module tb_en_reg_pipe;

  localparam int unsigned W = 16;

  logic          clk;
  logic          CLRN;
  logic [1:0]    in_vld_t, in_rdy_t, out_vld_t, out_rdy_t, flush_t;
  logic [W-1:0]  d_t [2];
  logic [W-1:0]  q_t [2];
`ifdef EN_REG_PIPE_OCC_EN
  logic [2:0]    occ0;
  logic [0:0]    occ1;
`endif

  int n_checks = 0;
  int n_err    = 0;

  en_reg_pipe #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .CLRN(CLRN), .in_vld(in_vld_t[0]), .in_rdy(in_rdy_t[0]), .D(d_t[0]),
    .FLUSH(flush_t[0]), .out_vld(out_vld_t[0]), .out_rdy(out_rdy_t[0]), .Q(q_t[0])
`ifdef EN_REG_PIPE_OCC_EN
    , .OCC(occ0)
`endif
  );

  en_reg_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
    .clk(clk), .CLRN(CLRN), .in_vld(in_vld_t[1]), .in_rdy(in_rdy_t[1]), .D(d_t[1]),
    .FLUSH(flush_t[1]), .out_vld(out_vld_t[1]), .out_rdy(out_rdy_t[1]), .Q(q_t[1])
`ifdef EN_REG_PIPE_OCC_EN
    , .OCC(occ1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: words sit in slots; each edge every word moves one slot
  // forward when the slot ahead is free after its own occupant has moved.
  int            depth_m [2] = '{4, 1};
  bit            mv [2][4];
  logic [W-1:0]  md [2][4];
  int            mcnt [2];

  function automatic bit m_in_rdy(input int k);
    return !flush_t[k] && (mcnt[k] < depth_m[k] || out_rdy_t[k]);
  endfunction

  function automatic bit m_out_vld(input int k);
    return mv[k][depth_m[k]-1];
  endfunction

  task automatic m_step(input int k);
    int L;
    bit acc, take;
    L    = depth_m[k] - 1;
    acc  = in_vld_t[k] && m_in_rdy(k);
    take = mv[k][L] && out_rdy_t[k];
    if (flush_t[k]) begin
      for (int i = 0; i < 4; i++) mv[k][i] = 1'b0;
      mcnt[k] = 0;
    end else begin
      if (take) mv[k][L] = 1'b0;
      for (int i = L - 1; i >= 0; i--) begin
        if (mv[k][i] && !mv[k][i+1]) begin
          mv[k][i+1] = 1'b1;
          md[k][i+1] = md[k][i];
          mv[k][i]   = 1'b0;
        end
      end
      if (acc) begin
        mv[k][0] = 1'b1;
        md[k][0] = d_t[k];
      end
      mcnt[k] = mcnt[k] + int'(acc) - int'(take);
    end
  endtask

  always @(posedge clk) begin
    if (!CLRN) begin
      for (int k = 0; k < 2; k++) begin
        mcnt[k] = 0;
        for (int i = 0; i < 4; i++) begin
          mv[k][i] = 1'b0;
          md[k][i] = '0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) m_step(k);
    end
  end

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!CLRN) begin
        chk($sformatf("rst%0d_out_vld", k), 32'(out_vld_t[k]), 32'(0));
        chk($sformatf("rst%0d_q", k), 32'(q_t[k]), 32'(0));
        chk($sformatf("rst%0d_in_rdy", k), 32'(in_rdy_t[k]), 32'(!flush_t[k]));
      end else begin
        chk($sformatf("mon%0d_in_rdy", k), 32'(in_rdy_t[k]), 32'(m_in_rdy(k)));
        chk($sformatf("mon%0d_out_vld", k), 32'(out_vld_t[k]), 32'(m_out_vld(k)));
        if (m_out_vld(k))
          chk($sformatf("mon%0d_q", k), 32'(q_t[k]), 32'(md[k][depth_m[k]-1]));
      end
`ifdef EN_REG_PIPE_OCC_EN
      chk($sformatf("mon%0d_occ", k), (k == 0) ? 32'(occ0) : 32'(occ1),
          CLRN ? 32'(mcnt[k]) : 32'(0));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input bit v, input logic [W-1:0] d, input bit ordy, input bit fl);
    in_vld_t[0]  = v;
    d_t[0]       = d;
    out_rdy_t[0] = ordy;
    flush_t[0]   = fl;
  endtask

  task automatic chk_occ0(input string name, input int exp);
`ifdef EN_REG_PIPE_OCC_EN
    chk(name, 32'(occ0), 32'(exp));
`endif
  endtask

  typedef struct {
    bit           v;
    logic [W-1:0] d;
    bit           ordy;
    bit           e_rdy;
    bit           e_vld;
    logic [W-1:0] e_q;
    int           e_occ;
  } vec_t;

  vec_t         vt [13];
  logic [W-1:0] got [$];
  int           first;

  initial begin
    // Back-pressure: fill with out_rdy low, then drain.
    vt = '{
      '{1'b1, 16'hA000, 1'b0, 1'b1, 1'b0, 16'h0000, 0},
      '{1'b1, 16'hA001, 1'b0, 1'b1, 1'b0, 16'h0000, 1},
      '{1'b1, 16'hA002, 1'b0, 1'b1, 1'b0, 16'h0000, 2},
      '{1'b1, 16'hA003, 1'b0, 1'b1, 1'b0, 16'h0000, 3},
      '{1'b1, 16'hA004, 1'b0, 1'b0, 1'b1, 16'hA000, 4},
      '{1'b1, 16'hA004, 1'b0, 1'b0, 1'b1, 16'hA000, 4},
      '{1'b1, 16'hA004, 1'b1, 1'b1, 1'b1, 16'hA000, 4},
      '{1'b1, 16'hA005, 1'b1, 1'b1, 1'b1, 16'hA001, 4},
      '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA002, 4},
      '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA003, 3},
      '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA004, 2},
      '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'hA005, 1},
      '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 0}
    };

    CLRN = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_vld_t[k]  = 1'($urandom);
      out_rdy_t[k] = 1'($urandom);
      flush_t[k]   = 1'b0;
      d_t[k]       = 16'($urandom);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      in_vld_t[k] = 1'b0; out_rdy_t[k] = 1'b1; d_t[k] = '0;
    end
    CLRN = 1'b1;
    @(negedge clk);
    chk("reset_in_rdy0", 32'(in_rdy_t[0]), 32'(1));
    chk("reset_in_rdy1", 32'(in_rdy_t[1]), 32'(1));
    chk_occ0("reset_occ0", 0);
    step();

    // Streaming 0x0001..0x0010 with out_rdy held high.
    first = -1;
    for (int c = 0; c < 24; c++) begin
      if (c < 16) drv0(1'b1, 16'(c + 1), 1'b1, 1'b0);
      else        drv0(1'b0, 16'h0, 1'b1, 1'b0);
      @(negedge clk);
      if (c < 16) chk("stream_in_rdy", 32'(in_rdy_t[0]), 32'(1));
      if (out_vld_t[0]) begin
        if (first < 0) first = c;
        got.push_back(q_t[0]);
      end
      step();
    end
    chk("stream_first_valid_cycle", 32'(first), 32'(4));
    chk("stream_count", 32'(got.size()), 32'(16));
    for (int i = 0; i < got.size() && i < 16; i++)
      chk($sformatf("stream_word%0d", i), 32'(got[i]), 32'(i + 1));

    foreach (vt[r]) begin
      drv0(vt[r].v, vt[r].d, vt[r].ordy, 1'b0);
      @(negedge clk);
      chk($sformatf("bp%0d_in_rdy", r), 32'(in_rdy_t[0]), 32'(vt[r].e_rdy));
      chk($sformatf("bp%0d_out_vld", r), 32'(out_vld_t[0]), 32'(vt[r].e_vld));
      if (vt[r].e_vld) chk($sformatf("bp%0d_q", r), 32'(q_t[0]), 32'(vt[r].e_q));
      chk_occ0($sformatf("bp%0d_occ", r), vt[r].e_occ);
      step();
    end

    // Bubble collapse: 0xB002 closes the gap behind a stalled 0xB001.
    drv0(1'b1, 16'hB001, 1'b0, 1'b0); step();
    drv0(1'b0, 16'h0, 1'b0, 1'b0); repeat (4) step();
    drv0(1'b1, 16'hB002, 1'b0, 1'b0);
    @(negedge clk);
    chk("bub_in_rdy", 32'(in_rdy_t[0]), 32'(1));
    step();
    drv0(1'b0, 16'h0, 1'b0, 1'b0); repeat (3) step();
    @(negedge clk);
    chk("bub_out_vld", 32'(out_vld_t[0]), 32'(1));
    chk("bub_q_head", 32'(q_t[0]), 32'hB001);
    chk_occ0("bub_occ", 2);
    drv0(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    @(negedge clk);
    chk("bub_next_vld", 32'(out_vld_t[0]), 32'(1));
    chk("bub_next_q", 32'(q_t[0]), 32'hB002);
    step();
    @(negedge clk);
    chk("bub_drained", 32'(out_vld_t[0]), 32'(0));

    // Flush with three words in flight and a word offered in the flush cycle.
    drv0(1'b1, 16'hC001, 1'b0, 1'b0); step();
    drv0(1'b1, 16'hC002, 1'b0, 1'b0); step();
    drv0(1'b1, 16'hC003, 1'b0, 1'b0); step();
    drv0(1'b0, 16'h0, 1'b0, 1'b0); repeat (2) step();
    @(negedge clk);
    chk("fl_pre_q", 32'(q_t[0]), 32'hC001);
    chk_occ0("fl_pre_occ", 3);
    drv0(1'b1, 16'hC0DE, 1'b1, 1'b1);
    @(negedge clk);
    chk("fl_in_rdy", 32'(in_rdy_t[0]), 32'(0));
    step();
    drv0(1'b0, 16'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("fl_out_vld", 32'(out_vld_t[0]), 32'(0));
    chk_occ0("fl_occ", 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("fl_no_c0de", 32'(out_vld_t[0]), 32'(0));
      step();
    end

    // DEPTH=1: full stage accepts and emits in the same cycle.
    in_vld_t[1] = 1'b1; d_t[1] = 16'h1111; out_rdy_t[1] = 1'b0; flush_t[1] = 1'b0;
    step();
    @(negedge clk);
    chk("d1_full_in_rdy", 32'(in_rdy_t[1]), 32'(0));
    chk("d1_full_q", 32'(q_t[1]), 32'h1111);
    d_t[1] = 16'h2222; out_rdy_t[1] = 1'b1;
    #1;
    chk("d1_pass_in_rdy", 32'(in_rdy_t[1]), 32'(1));
    step();
    @(negedge clk);
    chk("d1_pass_vld", 32'(out_vld_t[1]), 32'(1));
    chk("d1_pass_q", 32'(q_t[1]), 32'h2222);
    in_vld_t[1] = 1'b0;
    step();
    @(negedge clk);
    chk("d1_empty", 32'(out_vld_t[1]), 32'(0));

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_vld_t[k]  = ($urandom % 4) != 0;
        out_rdy_t[k] = ($urandom % 3) != 0;
        flush_t[k]   = ($urandom % 40) == 0;
        d_t[k]       = 16'($urandom);
      end
      step();
    end

    // Reset asserted mid-stream, between clock edges.
    for (int k = 0; k < 2; k++) begin
      in_vld_t[k] = 1'b1; out_rdy_t[k] = 1'b0; flush_t[k] = 1'b0;
    end
    repeat (5) step();
    #2;
    CLRN = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_vld", 32'(out_vld_t[0]), 32'(0));
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) in_vld_t[k] = 1'b0;
    CLRN = 1'b1;
    @(negedge clk);
    chk("post_rst_vld0", 32'(out_vld_t[0]), 32'(0));
    chk("post_rst_rdy0", 32'(in_rdy_t[0]), 32'(1));
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
